mux4_rr_arbiter: RTL and testbench



---
 rtl/mux4_rr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_mux4_rr_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter that shares one 4-to-1 channel multiplexer between four
// requesters. It grants bounded bursts and registers the selected word into a
// valid/ready output stage. The mux select is driven with the established
// encoding ch_0=2'b11, ch_1=2'b10, ch_2=2'b01, ch_3=2'b00 (select = ~index).
module mux4_rr_arbiter #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] ch_0,
    input  logic [DATA_W-1:0] ch_1,
    input  logic [DATA_W-1:0] ch_2,
    input  logic [DATA_W-1:0] ch_3,
    output logic [3:0]        ch_ready,
    input  logic              out_ready,
    output logic [1:0]        select,
    output logic [3:0]        gnt,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        gnt_q, gnt_d;
    logic [1:0]        sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              valid_q, valid_d;

    logic              pick_found;
    logic [1:0]        pick_idx;
    logic [1:0]        grant_idx;
    logic [DATA_W-1:0] mux_word;
    logic [CNT_W-1:0]  cnt_inc;
    logic              in_grant;
    logic              space;
    logic              req_g;
    logic              xfer;
    logic              last_word;

    // While granted, select always equals ~index of the granted channel, so
    // the granted index is recovered from it instead of being stored twice.
    assign grant_idx = ~sel_q;
    assign in_grant  = (state_q == S_GRANT);
    assign space     = !valid_q || out_ready;
    assign req_g     = req[grant_idx];
    assign xfer      = in_grant && req_g && space;
    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign last_word = (cnt_inc == CNT_W'(MAX_BURST));

    // Only the granted channel may see ready; gnt_q is one-hot in GRANT.
    assign ch_ready  = (in_grant && space) ? (gnt_q & req) : 4'b0000;

    assign select    = sel_q;
    assign gnt       = gnt_q;
    assign data_out  = data_q;
    assign out_valid = valid_q;

    // Round-robin scan: first set request starting at ptr and wrapping.
    always_comb begin
        // NOTE: every variable written here gets a default first so that no
        // path leaves it unassigned, which would otherwise infer a latch.
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 0; k < 4; k++) begin
            logic [1:0] idx;
            idx = ptr_q + 2'(k);
            if (!pick_found && req[idx]) begin
                pick_found = 1'b1;
                pick_idx   = idx;
            end
        end
    end

    // The shared 4-to-1 channel multiplexer, steered by the registered select.
    always_comb begin
        mux_word = ch_3;
        case (sel_q)
            2'b11:   mux_word = ch_0;
            2'b10:   mux_word = ch_1;
            2'b01:   mux_word = ch_2;
            default: mux_word = ch_3;
        endcase
    end

    // Arbitration FSM next state: grant on request, release on drop or burst end.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        case (state_q)
            S_IDLE: begin
                // select only changes here, so the mux is stable for a grant.
                if (pick_found) begin
                    state_d = S_GRANT;
                    gnt_d   = 4'b0001 << pick_idx;
                    sel_d   = ~pick_idx;
                    cnt_d   = '0;
                end
            end
            S_GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_inc;
                    if (last_word) begin
                        state_d = S_IDLE;
                        gnt_d   = 4'b0000;
                        ptr_d   = grant_idx + 2'd1;
                    end
                end else if (!req_g) begin
                    state_d = S_IDLE;
                    gnt_d   = 4'b0000;
                    ptr_d   = grant_idx + 2'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    // Output stage: capture on transfer, drop valid once consumed.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        if (xfer) begin
            data_d  = mux_word;
            valid_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State registers with synchronous reset overriding everything.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= 2'd0;
            cnt_q   <= '0;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'b11;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter. Expected output words are queued when
// stimulus is issued; a monitor pops and compares each word as it is consumed.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] ch_0, ch_1, ch_2, ch_3;
    logic [3:0] ch_ready;
    logic       out_ready;
    logic [1:0] select;
    logic [3:0] gnt;
    logic [7:0] data_out;
    logic       out_valid;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    mux4_rr_arbiter #(.DATA_W(8), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ch_0      (ch_0),
        .ch_1      (ch_1),
        .ch_2      (ch_2),
        .ch_3      (ch_3),
        .ch_ready  (ch_ready),
        .out_ready (out_ready),
        .select    (select),
        .gnt       (gnt),
        .data_out  (data_out),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        tick();
        tick();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_select", select, 2'b11);
        check("rst_valid", out_valid, 1'b0);
        check("rst_data", data_out, 8'h00);
        check("rst_ch_ready", ch_ready, 4'b0000);
        rst = 1'b0;
    endtask

    // Monitor: inputs are stable at the falling edge, so valid&ready here
    // means the word is consumed at the coming rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("stream_unexpected_word", {24'h0, data_out}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("stream_word", data_out, e);
            end
        end
    end

    logic [3:0] rr_gnt[5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    logic [1:0] rr_sel[5] = '{2'b11, 2'b10, 2'b01, 2'b00, 2'b11};
    logic [7:0] rr_dat[5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        out_ready = 1'b1;
        ch_0 = 8'h00; ch_1 = 8'h00; ch_2 = 8'h00; ch_3 = 8'h00;

        // Single requester: 4-word burst of A5.
        do_reset();
        ch_0 = 8'hA5;
        req  = 4'b0001;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'hA5);
        tick();
        check("single_gnt", gnt, 4'b0001);
        check("single_sel", select, 2'b11);
        check("single_valid0", out_valid, 1'b0);
        check("single_ch_ready", ch_ready, 4'b0001);
        for (int w = 0; w < 4; w++) begin
            tick();
            check("single_data", data_out, 8'hA5);
            check("single_valid", out_valid, 1'b1);
            check("single_gnt_burst", gnt, (w == 3) ? 4'b0000 : 4'b0001);
        end
        req = 4'b0000;
        tick();
        check("single_idle_valid", out_valid, 1'b0);
        check("single_idle_gnt", gnt, 4'b0000);
        // Pointer now at ch_1: ch_1 wins over ch_0.
        ch_1 = 8'h11;
        req  = 4'b0011;
        tick();
        check("ptr_gnt", gnt, 4'b0010);
        check("ptr_sel", select, 2'b10);
        req = 4'b0000;
        tick();
        check("drop_nodata_gnt", gnt, 4'b0000);
        check("drop_nodata_valid", out_valid, 1'b0);
        check("drop_sel_holds", select, 2'b10);
        tick();

        // All four requesting: rotation with one idle cycle between grants.
        do_reset();
        ch_0 = 8'h10; ch_1 = 8'h11; ch_2 = 8'h12; ch_3 = 8'h13;
        req  = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            for (int i = 0; i < 4; i++) exp_q.push_back(rr_dat[k]);
            tick();
            check("rr_gnt", gnt, rr_gnt[k]);
            check("rr_sel", select, rr_sel[k]);
            for (int w = 0; w < 4; w++) begin
                tick();
                check("rr_data", data_out, rr_dat[k]);
                check("rr_valid", out_valid, 1'b1);
                check("rr_gnt_burst", gnt, (w == 3) ? 4'b0000 : rr_gnt[k]);
            end
        end
        req = 4'b0000;
        tick();

        // Back-pressure on ch_2 (pointer is at ch_1, scan reaches ch_2).
        ch_2 = 8'h3C;
        req  = 4'b0100;
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h3C);
        tick();
        check("bp_gnt", gnt, 4'b0100);
        check("bp_sel", select, 2'b01);
        check("bp_ch_ready_open", ch_ready, 4'b0100);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_data_held", data_out, 8'h3C);
            check("bp_valid_held", out_valid, 1'b1);
            check("bp_ch_ready_blocked", ch_ready, 4'b0000);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ch_ready_resume", ch_ready, 4'b0100);
        for (int w = 0; w < 3; w++) begin
            tick();
            check("bp_resume_data", data_out, 8'h3C);
            check("bp_resume_valid", out_valid, 1'b1);
            check("bp_resume_gnt", gnt, (w == 2) ? 4'b0000 : 4'b0100);
        end
        req = 4'b0000;
        tick();

        // Early drop of ch_1 after 2 words, ch_3 still requesting.
        do_reset();
        ch_1 = 8'h21; ch_3 = 8'h43;
        req  = 4'b1010;
        exp_q.push_back(8'h21);
        exp_q.push_back(8'h21);
        tick();
        check("drop_gnt", gnt, 4'b0010);
        check("drop_sel", select, 2'b10);
        tick();
        check("drop_data1", data_out, 8'h21);
        tick();
        check("drop_data2", data_out, 8'h21);
        req = 4'b1000;
        tick();
        check("drop_release_gnt", gnt, 4'b0000);
        check("drop_release_valid", out_valid, 1'b0);
        tick();
        check("drop_next_gnt", gnt, 4'b1000);
        check("drop_next_sel", select, 2'b00);

        // Reset mid-burst: ch_3 word 1 held, reset lands before word 2.
        tick();
        check("mid_data", data_out, 8'h43);
        check("mid_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        check("mid_rst_gnt", gnt, 4'b0000);
        check("mid_rst_sel", select, 2'b11);
        check("mid_rst_valid", out_valid, 1'b0);
        check("mid_rst_data", data_out, 8'h00);
        rst  = 1'b0;
        ch_0 = 8'h01;
        req  = 4'b1111;
        tick();
        check("post_rst_gnt", gnt, 4'b0001);
        check("post_rst_sel", select, 2'b11);

        // Simultaneous consume of 01 and capture of 02.
        req = 4'b0001;
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h02);
        tick();
        check("cc_data1", data_out, 8'h01);
        check("cc_valid1", out_valid, 1'b1);
        ch_0 = 8'h02;
        tick();
        check("cc_data2", data_out, 8'h02);
        check("cc_valid2", out_valid, 1'b1);
        req = 4'b0000;
        tick();
        check("cc_end_gnt", gnt, 4'b0000);
        check("cc_end_valid", out_valid, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
